controladora_multicanal: RTL and testbench
==========================================

Name: controladora_multicanal

Overview:
- N-channel lamp controller. Each channel runs an independent four-state automatic/manual FSM driving lamp, mode LED and enable.
- New in this generation:
  - rising-edge detection on push-buttons, so a held button acts once;
  - configurable auto-on hold timeout;
  - a global count of lit channels.
- Sits between debounced panel buttons/sensors and lamp drivers.

Parameters:
- N_CH, 4, number of independent channels (1..16).
- TIMER_W, 8, width of per-channel hold counter.
- HOLD_CYCLES, 200, auto-on duration in clk cycles; 0 disables timeout; must be < 2**TIMER_W.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset.
- modo_btn  input  N_CH  per-channel mode button (auto <-> manual), level, synchronous to clk.
- man_btn  input  N_CH  per-channel manual toggle button, level.
- sens_on  input  N_CH  per-channel auto turn-on request, level.
- sens_off  input  N_CH  per-channel auto turn-off request, level.
- saida  output  N_CH  lamp drive.
- led  output  N_CH  manual-mode indicator.
- enable  output  N_CH  high only while lit in auto mode.
- n_acesas  output  $clog2(N_CH+1)  number of channels with saida=1.

Behaviour:
- Reset (rst=0, asynchronous):
  - every channel -> AUTO_OFF; hold counters = 0;
  - button history registers = 1, so a button held across reset release is NOT a press;
  - all outputs 0; n_acesas=0.
- Edge detect:
  - press_x[i] = btn_x[i] & ~hist_x[i]; hist_x <= btn_x every cycle;
  - a press acts at the same edge where the button is first sampled high;
  - a held button yields exactly one press.
- States per channel, with output decode (combinational from state):
  - AUTO_OFF: saida 0, led 0, enable 0.
  - AUTO_ON: saida 1, led 0, enable 1.
  - MAN_OFF: saida 0, led 1, enable 0.
  - MAN_ON: saida 1, led 1, enable 0.
- Transitions (per edge, listed in priority order):
  - AUTO_OFF:
    - sens_on -> AUTO_ON, cnt <= HOLD_CYCLES-1;
    - else modo press -> MAN_OFF;
    - else stay.
  - AUTO_ON:
    - sens_off -> AUTO_OFF;
    - else modo press -> MAN_OFF;
    - else sens_on -> stay, cnt <= HOLD_CYCLES-1 (reload);
    - else if HOLD_CYCLES!=0 and cnt==0 -> AUTO_OFF;
    - else cnt <= cnt-1 (when HOLD_CYCLES!=0).
  - MAN_OFF:
    - modo press -> AUTO_ON, cnt <= HOLD_CYCLES-1;
    - else man press -> MAN_ON;
    - else stay.
  - MAN_ON:
    - modo press -> AUTO_ON, cnt loaded;
    - else man press -> MAN_OFF;
    - else stay.
  - Unreachable encodings -> AUTO_OFF.
- Timing:
  - With no further events, AUTO_ON lasts exactly HOLD_CYCLES cycles after entry/last reload.
  - sens_on/sens_off are levels; they are ignored in manual states.
  - man press is ignored in auto states.
- Channels fully independent; simultaneous events on different channels are each handled in the same cycle.
- n_acesas:
  - registered popcount of next-state saida; updates in the same cycle as saida;
  - max value N_CH, no overflow.
- Reset mid-operation:
  - immediate return to reset values regardless of counter or state;
  - no pending press survives.

Test Plan (N_CH=4, HOLD_CYCLES=5):
- Release rst with modo_btn[0]=1 held -> ch0 stays AUTO_OFF (saida=0, led=0); drop and raise modo_btn[0] -> ch0 MAN_OFF, led[0]=1 after that edge.
- sens_on[1] pulse 1 cycle -> saida[1]=enable[1]=1 for exactly 5 cycles, then 0; n_acesas 0->1->0.
- ch1 AUTO_ON, sens_on[1] re-pulsed at cycle 3 -> lamp stays on 5 cycles after the re-pulse (8 total).
- ch2: assert sens_on[2] and sens_off[2] together while AUTO_ON -> AUTO_OFF; assert sens_on[2] and modo_btn[2] rising together in AUTO_OFF -> AUTO_ON (sensor wins).
- ch3 MAN_OFF, hold man_btn[3] 10 cycles -> single toggle to MAN_ON (saida=1, led=1, enable=0); modo press -> AUTO_ON with timeout 5.
- All 4 channels lit, then rst=0 mid-count -> all outputs 0 asynchronously, n_acesas=0; after release all AUTO_OFF.

Source files
------------

// File: rtl/controladora_multicanal.sv
`default_nettype none
// ============================================================================
//  Module   : controladora_multicanal
//  Purpose  : N-channel lamp controller. Each channel runs an independent
//             four-state automatic/manual FSM that drives its lamp, its
//             manual-mode LED and its auto-mode enable. Push-buttons are
//             rising-edge detected so a held button acts only once, the
//             auto-on period is bounded by a configurable hold timeout, and
//             a registered count of lit channels is provided.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//     clk       in   1                 system clock, rising edge
//     rst       in   1                 asynchronous reset, active low
//     modo_btn  in   N_CH              mode button (auto <-> manual), level
//     man_btn   in   N_CH              manual on/off toggle button, level
//     sens_on   in   N_CH              auto turn-on request, level
//     sens_off  in   N_CH              auto turn-off request, level
//     saida     out  N_CH              lamp drive
//     led       out  N_CH              manual-mode indicator
//     enable    out  N_CH              high only while lit in auto mode
//     n_acesas  out  clog2(N_CH+1)     number of channels with saida = 1
// ============================================================================
module controladora_multicanal #(
   parameter int N_CH        = 4,
   parameter int TIMER_W     = 8,
   parameter int HOLD_CYCLES = 200
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [N_CH-1:0]             modo_btn,
   input  logic [N_CH-1:0]             man_btn,
   input  logic [N_CH-1:0]             sens_on,
   input  logic [N_CH-1:0]             sens_off,
   output logic [N_CH-1:0]             saida,
   output logic [N_CH-1:0]             led,
   output logic [N_CH-1:0]             enable,
   output logic [$clog2(N_CH+1)-1:0]   n_acesas
);

   localparam int c_cnt_w = $clog2(N_CH + 1);

   // A zero hold time means "no timeout"; keep the reload value legal anyway.
   localparam bit                 c_timeout_en = (HOLD_CYCLES != 0);
   localparam logic [TIMER_W-1:0] c_reload     = (HOLD_CYCLES == 0) ? '0
                                                : TIMER_W'(HOLD_CYCLES - 1);

   typedef enum logic [1:0] {
      AUTO_OFF = 2'b00,
      AUTO_ON  = 2'b01,
      MAN_OFF  = 2'b10,
      MAN_ON   = 2'b11
   } state_t;

   // -------------------------------------------------------------------------
   // Button edge detection. History resets to all-ones so that a button
   // already held while reset is released is not mistaken for a press.
   // -------------------------------------------------------------------------
   logic [N_CH-1:0] modo_hist_q, modo_hist_d;
   logic [N_CH-1:0] man_hist_q,  man_hist_d;
   logic [N_CH-1:0] modo_press;
   logic [N_CH-1:0] man_press;

   always_comb begin
      modo_hist_d = modo_btn;
      man_hist_d  = man_btn;
      modo_press  = modo_btn & ~modo_hist_q;
      man_press   = man_btn  & ~man_hist_q;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         modo_hist_q <= '1;
         man_hist_q  <= '1;
      end else begin
         modo_hist_q <= modo_hist_d;
         man_hist_q  <= man_hist_d;
      end
   end

   // Next-state lamp drive of every channel, used for the lit-channel count.
   logic [N_CH-1:0] saida_d;

   // -------------------------------------------------------------------------
   // Per-channel FSM and hold counter
   // -------------------------------------------------------------------------
   generate
      for (genvar i = 0; i < N_CH; i++) begin : g_ch
         state_t             state_q, state_d;
         logic [TIMER_W-1:0] cnt_q,   cnt_d;

         always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            case (state_q)
               AUTO_OFF: begin
                  // The sensor outranks a simultaneous mode press.
                  if (sens_on[i]) begin
                     state_d = AUTO_ON;
                     cnt_d   = c_reload;
                  end else if (modo_press[i]) begin
                     state_d = MAN_OFF;
                  end
               end
               AUTO_ON: begin
                  if (sens_off[i]) begin
                     state_d = AUTO_OFF;
                  end else if (modo_press[i]) begin
                     state_d = MAN_OFF;
                  end else if (sens_on[i]) begin
                     cnt_d = c_reload;
                  end else if (c_timeout_en) begin
                     // Counter is loaded with HOLD-1 and the exit happens on
                     // the edge that finds it at zero: HOLD lit cycles total.
                     if (cnt_q == '0) begin
                        state_d = AUTO_OFF;
                     end else begin
                        cnt_d = cnt_q - 1'b1;
                     end
                  end
               end
               MAN_OFF: begin
                  if (modo_press[i]) begin
                     state_d = AUTO_ON;
                     cnt_d   = c_reload;
                  end else if (man_press[i]) begin
                     state_d = MAN_ON;
                  end
               end
               MAN_ON: begin
                  if (modo_press[i]) begin
                     state_d = AUTO_ON;
                     cnt_d   = c_reload;
                  end else if (man_press[i]) begin
                     state_d = MAN_OFF;
                  end
               end
               default: begin
                  state_d = AUTO_OFF;
               end
            endcase
         end

         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               state_q <= AUTO_OFF;
               cnt_q   <= '0;
            end else begin
               state_q <= state_d;
               cnt_q   <= cnt_d;
            end
         end

         assign saida[i]   = (state_q == AUTO_ON) || (state_q == MAN_ON);
         assign led[i]     = (state_q == MAN_OFF) || (state_q == MAN_ON);
         assign enable[i]  = (state_q == AUTO_ON);
         assign saida_d[i] = (state_d == AUTO_ON) || (state_d == MAN_ON);
      end
   endgenerate

   // -------------------------------------------------------------------------
   // Lit-channel count: popcount of the next-state lamp drive, registered so
   // it changes on the same edge as saida itself.
   // -------------------------------------------------------------------------
   logic [c_cnt_w-1:0] n_acesas_q, n_acesas_d;

   always_comb begin
      n_acesas_d = '0;
      for (int k = 0; k < N_CH; k++) begin
         n_acesas_d = n_acesas_d + c_cnt_w'(saida_d[k]);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         n_acesas_q <= '0;
      end else begin
         n_acesas_q <= n_acesas_d;
      end
   end

   assign n_acesas = n_acesas_q;

endmodule
`default_nettype wire

// File: tb/tb_controladora_multicanal.sv
`default_nettype none
// ============================================================================
//  Module   : tb_controladora_multicanal
//  Purpose  : Self-checking bench for controladora_multicanal (N_CH=4,
//             HOLD_CYCLES=5). Directed per-cycle vectors carry hand-computed
//             expected outputs into a scoreboard queue; an independent
//             monitor pops and compares after each rising edge (or after an
//             asynchronous reset assertion).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_controladora_multicanal;

   localparam int N_CH = 4;

   logic            clk = 1'b0;
   logic            rst = 1'b0;
   logic [N_CH-1:0] modo_btn = '0;
   logic [N_CH-1:0] man_btn  = '0;
   logic [N_CH-1:0] sens_on  = '0;
   logic [N_CH-1:0] sens_off = '0;
   logic [N_CH-1:0] saida;
   logic [N_CH-1:0] led;
   logic [N_CH-1:0] enable;
   logic [2:0]      n_acesas;

   controladora_multicanal #(
      .N_CH        (4),
      .TIMER_W     (8),
      .HOLD_CYCLES (5)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .modo_btn (modo_btn),
      .man_btn  (man_btn),
      .sens_on  (sens_on),
      .sens_off (sens_off),
      .saida    (saida),
      .led      (led),
      .enable   (enable),
      .n_acesas (n_acesas)
   );

   always #5 clk = ~clk;

   typedef struct {
      string      name;
      logic [3:0] saida;
      logic [3:0] led;
      logic [3:0] en;
      logic [2:0] n;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_pass   = 0;
   bit   stim_done = 1'b0;
   event async_ev;

   // Monitor: one expectation per rising edge, plus one per async reset event.
   initial begin
      forever begin
         @(posedge clk or async_ev);
         #1;
         if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            n_checks++;
            if (saida === e.saida && led === e.led && enable === e.en && n_acesas === e.n) begin
               n_pass++;
            end else begin
               $display("FAIL %s: got saida=%b led=%b enable=%b n_acesas=%0d, want saida=%b led=%b enable=%b n_acesas=%0d",
                        e.name, saida, led, enable, n_acesas, e.saida, e.led, e.en, e.n);
            end
         end
      end
   end

   // One clock cycle of stimulus with the outputs expected after its edge.
   task automatic cyc(input string nm, input logic r,
                      input logic [3:0] mo, input logic [3:0] ma,
                      input logic [3:0] son, input logic [3:0] soff,
                      input logic [3:0] es, input logic [3:0] el,
                      input logic [3:0] ee, input logic [2:0] en);
      exp_t e;
      @(negedge clk);
      rst      = r;
      modo_btn = mo;
      man_btn  = ma;
      sens_on  = son;
      sens_off = soff;
      e.name = nm; e.saida = es; e.led = el; e.en = ee; e.n = en;
      exp_q.push_back(e);
   endtask

   initial begin
      // ---- reset with modo_btn[0] held -----------------------------------
      cyc("reset0",   0, 4'b0001, 0, 0, 0, 4'b0000, 4'b0000, 4'b0000, 0);
      cyc("reset1",   0, 4'b0001, 0, 0, 0, 4'b0000, 4'b0000, 4'b0000, 0);
      cyc("held_rel", 1, 4'b0001, 0, 0, 0, 4'b0000, 4'b0000, 4'b0000, 0);
      cyc("held_2",   1, 4'b0001, 0, 0, 0, 4'b0000, 4'b0000, 4'b0000, 0);
      cyc("modo_low", 1, 4'b0000, 0, 0, 0, 4'b0000, 4'b0000, 4'b0000, 0);
      cyc("ch0_man",  1, 4'b0001, 0, 0, 0, 4'b0000, 4'b0001, 4'b0000, 0);
      cyc("ch0_hold", 1, 4'b0001, 0, 0, 0, 4'b0000, 4'b0001, 4'b0000, 0);
      cyc("ch0_rel",  1, 4'b0000, 0, 0, 0, 4'b0000, 4'b0001, 4'b0000, 0);

      // ---- ch1 single sensor pulse: lit exactly 5 cycles ----------------
      cyc("p_on",     1, 0, 0, 4'b0010, 0, 4'b0010, 4'b0001, 4'b0010, 1);
      for (int k = 0; k < 4; k++)
         cyc("p_hold", 1, 0, 0, 0, 0, 4'b0010, 4'b0001, 4'b0010, 1);
      cyc("p_off",    1, 0, 0, 0, 0, 4'b0000, 4'b0001, 4'b0000, 0);

      // ---- ch1 reload at cycle 3: lit 8 cycles --------------------------
      cyc("r_on",     1, 0, 0, 4'b0010, 0, 4'b0010, 4'b0001, 4'b0010, 1);
      cyc("r_c1",     1, 0, 0, 0,       0, 4'b0010, 4'b0001, 4'b0010, 1);
      cyc("r_c2",     1, 0, 0, 0,       0, 4'b0010, 4'b0001, 4'b0010, 1);
      cyc("r_reload", 1, 0, 0, 4'b0010, 0, 4'b0010, 4'b0001, 4'b0010, 1);
      for (int k = 0; k < 4; k++)
         cyc("r_hold", 1, 0, 0, 0, 0, 4'b0010, 4'b0001, 4'b0010, 1);
      cyc("r_off",    1, 0, 0, 0, 0, 4'b0000, 4'b0001, 4'b0000, 0);

      // ---- ch2 sensor priorities ----------------------------------------
      cyc("c2_on",    1, 0,       0, 4'b0100, 0,       4'b0100, 4'b0001, 4'b0100, 1);
      cyc("c2_both",  1, 0,       0, 4'b0100, 4'b0100, 4'b0000, 4'b0001, 4'b0000, 0);
      cyc("c2_sensw", 1, 4'b0100, 0, 4'b0100, 0,       4'b0100, 4'b0001, 4'b0100, 1);
      cyc("c2_off",   1, 0,       0, 0,       4'b0100, 4'b0000, 4'b0001, 4'b0000, 0);

      // ---- ch3 manual toggle with long hold; ch1 man press ignored ------
      cyc("c3_man",   1, 4'b1000, 0, 0, 0, 4'b0000, 4'b1001, 4'b0000, 0);
      cyc("c3_mrel",  1, 0,       0, 0, 0, 4'b0000, 4'b1001, 4'b0000, 0);
      for (int k = 0; k < 10; k++)
         cyc("c3_mon", 1, 0, 4'b1010, 0, 0, 4'b1000, 4'b1001, 4'b0000, 1);
      cyc("c3_mrls",  1, 0, 0, 0, 0, 4'b1000, 4'b1001, 4'b0000, 1);
      cyc("c3_auto",  1, 4'b1000, 0, 0, 0, 4'b1000, 4'b0001, 4'b1000, 1);
      for (int k = 0; k < 4; k++)
         cyc("c3_ahold", 1, 4'b1000, 0, 0, 0, 4'b1000, 4'b0001, 4'b1000, 1);
      cyc("c3_tout",  1, 4'b1000, 0, 0, 0, 4'b0000, 4'b0001, 4'b0000, 0);
      // sensor ignored while ch0 is manual
      cyc("c0_ignsn", 1, 0, 0, 4'b0001, 0, 4'b0000, 4'b0001, 4'b0000, 0);

      // ---- all lit, then asynchronous reset mid-count -------------------
      cyc("all_on",   1, 0, 4'b0001, 4'b1110, 0, 4'b1111, 4'b0001, 4'b1110, 4);
      cyc("all_c1",   1, 0, 4'b0001, 0,       0, 4'b1111, 4'b0001, 4'b1110, 4);
      @(posedge clk);
      #2;
      rst = 1'b0;
      begin
         exp_t e;
         e.name = "async_rst"; e.saida = 0; e.led = 0; e.en = 0; e.n = 0;
         exp_q.push_back(e);
      end
      -> async_ev;
      cyc("rst_hold", 0, 0, 4'b0001, 0, 0, 4'b0000, 4'b0000, 4'b0000, 0);
      cyc("post_rel", 1, 0, 4'b0001, 0, 0, 4'b0000, 4'b0000, 4'b0000, 0);
      cyc("post_2",   1, 0, 4'b0001, 0, 0, 4'b0000, 4'b0000, 4'b0000, 0);
      cyc("post_son", 1, 0, 0, 4'b0001, 0, 4'b0001, 4'b0000, 4'b0001, 1);
      cyc("post_sof", 1, 0, 0, 0, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 0);
      stim_done = 1'b1;
   end

   initial begin
      wait (stim_done);
      for (int k = 0; k < 20 && exp_q.size() > 0; k++) @(negedge clk);
      if (exp_q.size() > 0) begin
         n_checks++;
         $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
      end
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish, want finish");
      $display("%0d/%0d checks passed", n_pass, n_checks + 1);
      $finish;
   end

endmodule
`default_nettype wire
